memory_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-fetch path and the data-memory path of the CPU. Accepts read requests from the fetch side and read/write requests from the data side. Grants exactly one owner at a time and holds that grant until the RAM reports completion. Returns data and per-requester wait signals to the datapath. Data requests have priority; a starvation counter guarantees forward progress for instruction fetch.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/memory_arbiter_if.sv | 38 +++
 rtl/memory_arbiter.sv | 101 ++++++++++
 tb/tb_memory_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake, data word and memory arbiter state/grant encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_FETCH = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the CPU paths, the arbiter and the single RAM port.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic [1:0] grant;

    // Arbiter side.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, grant
    );

    // Requester / RAM side.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, grant
    );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data memory; data has priority,
// a saturating starvation counter forces fetch through after STARVE_LIMIT contested wins.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              CLK,
    input logic              nRST,
    memory_arbiter_if.slave  bus
);

    localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    d_req;

    assign d_req = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;

        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.grant    = GRANT_NONE;
        // Non-owners stall whenever they are asking.
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;

        unique case (state_q)
            IDLE: begin
                if (d_req && bus.iREN) begin
                    if (starve_cnt_q == Limit) begin
                        state_d      = IGRANT;
                        starve_cnt_d = '0;
                    end else begin
                        state_d      = DGRANT;
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (d_req) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d      = IGRANT;
                    starve_cnt_d = '0;
                end
            end

            IGRANT: begin
                bus.grant = GRANT_FETCH;
                // A dropped request never signals completion.
                bus.iwait = ~(bus.iREN && (bus.ramstate == ACCESS));
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                        state_d = IDLE;
                    end
                end
            end

            DGRANT: begin
                bus.grant = GRANT_DATA;
                bus.dwait = ~(d_req && (bus.ramstate == ACCESS));
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scripted requesters, a latency-programmable RAM
// model and per-requester scoreboards checked on every completion.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        logic  wr;
        word_t addr;
        word_t val;
    } exp_t;

    logic CLK;
    logic nRST;

    memory_arbiter_if bus ();

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    exp_t iq[$];
    exp_t dq[$];

    int   ram_cnt;
    int   ram_lat = 2;
    bit   err_inject = 1'b0;
    logic ram_en;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic word_t pattern(word_t a);
        return 32'hDEADBEEF ^ ((a - 32'h40) * 32'h0101_0101);
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RAM model: answers ram_lat cycles after enables first rise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ram_cnt <= 0;
        else if (ram_en) ram_cnt <= ram_cnt + 1;
        else ram_cnt <= 0;
    end

    always_comb begin
        ram_en = bus.ramREN | bus.ramWEN;
        if (!ram_en) bus.ramstate = FREE;
        else if (ram_cnt == ram_lat) bus.ramstate = err_inject ? ERROR : ACCESS;
        else bus.ramstate = BUSY;
        bus.ramload = (ram_en && ram_cnt == ram_lat) ? pattern(bus.ramaddr) : 32'h0;
    end

    // Completion monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST) begin
            if (bus.iREN && !bus.iwait) begin
                if (iq.size() == 0) check_eq("i_unexpected", 32'd1, 32'd0);
                else begin
                    e = iq.pop_front();
                    check_eq("iload", bus.iload, e.val);
                    check_eq("i_ramaddr", bus.ramaddr, e.addr);
                    check_eq("i_grant", 32'(bus.grant), 32'(GRANT_FETCH));
                end
            end
            if ((bus.dREN | bus.dWEN) && !bus.dwait) begin
                if (dq.size() == 0) check_eq("d_unexpected", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    check_eq("d_grant", 32'(bus.grant), 32'(GRANT_DATA));
                    check_eq("d_ramaddr", bus.ramaddr, e.addr);
                    if (e.wr) begin
                        check_eq("d_ramWEN", 32'(bus.ramWEN), 32'd1);
                        check_eq("d_ramstore", bus.ramstore, e.val);
                    end else begin
                        check_eq("d_ramREN", 32'(bus.ramREN), 32'd1);
                        check_eq("dload", bus.dload, e.val);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit is_d, input string tag, output int cycles);
        cycles = 0;
        while ((is_d ? bus.dwait : bus.iwait) && cycles < 50) begin
            step();
            cycles++;
        end
        if (cycles >= 50) check_eq(tag, 32'd1, 32'd0);
    endtask

    initial begin
        int   n;
        int   dg;
        bit   seen;
        bit   upd;
        logic [1:0] prev;

        nRST       = 1'b0;
        bus.iREN   = 1'b0;
        bus.iaddr  = '0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        #1;
        check_eq("rst_grant", 32'(bus.grant), 32'(GRANT_NONE));
        check_eq("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check_eq("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        check_eq("rst_ramaddr", bus.ramaddr, 32'd0);
        check_eq("rst_ramstore", bus.ramstore, 32'd0);
        check_eq("rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
        bus.iREN = 1'b1;
        #1;
        check_eq("rst_iwait_follows", 32'(bus.iwait), 32'd1);
        bus.iREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // Fetch only.
        ram_lat = 2;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        iq.push_back('{wr: 1'b0, addr: 32'h40, val: 32'hDEADBEEF});
        #1;
        check_eq("f_c0_grant", 32'(bus.grant), 32'(GRANT_NONE));
        check_eq("f_c0_ramREN", 32'(bus.ramREN), 32'd0);
        step();
        check_eq("f_c1_grant", 32'(bus.grant), 32'(GRANT_FETCH));
        check_eq("f_c1_ramREN", 32'(bus.ramREN), 32'd1);
        check_eq("f_c1_ramaddr", bus.ramaddr, 32'h40);
        check_eq("f_c1_iwait", 32'(bus.iwait), 32'd1);
        wait_done(1'b0, "f_timeout", n);
        check_eq("f_latency", 32'(n + 1), 32'd3);
        step();
        bus.iREN = 1'b0;
        #1;
        check_eq("f_idle_grant", 32'(bus.grant), 32'(GRANT_NONE));
        check_eq("f_idle_ramREN", 32'(bus.ramREN), 32'd0);

        // Contested: data write wins, fetch stalls throughout.
        bus.iREN   = 1'b1;
        bus.iaddr  = 32'h44;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h80;
        bus.dstore = 32'h1234;
        dq.push_back('{wr: 1'b1, addr: 32'h80, val: 32'h1234});
        iq.push_back('{wr: 1'b0, addr: 32'h44, val: pattern(32'h44)});
        step();
        check_eq("c_grant", 32'(bus.grant), 32'(GRANT_DATA));
        check_eq("c_ramWEN", 32'(bus.ramWEN), 32'd1);
        check_eq("c_ramREN", 32'(bus.ramREN), 32'd0);
        check_eq("c_ramstore", bus.ramstore, 32'h1234);
        n = 0;
        while (bus.dwait && n < 50) begin
            check_eq("c_iwait_high", 32'(bus.iwait), 32'd1);
            step();
            n++;
        end
        if (n >= 50) check_eq("c_timeout", 32'd1, 32'd0);
        check_eq("c_iwait_at_dacc", 32'(bus.iwait), 32'd1);
        step();
        bus.dWEN = 1'b0;
        wait_done(1'b0, "c_f_timeout", n);
        step();
        bus.iREN = 1'b0;
        check_eq("c_cnt_clr", 32'(dut.starve_cnt_q), 32'd0);

        // Starvation: continuous data reads against a held fetch.
        ram_lat   = 1;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h48;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h100;
        dq.push_back('{wr: 1'b0, addr: 32'h100, val: pattern(32'h100)});
        iq.push_back('{wr: 1'b0, addr: 32'h48, val: pattern(32'h48)});
        #1;
        prev = bus.grant;
        dg   = 0;
        seen = 1'b0;
        upd  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (upd) begin
                bus.daddr = bus.daddr + 32'd4;
                dq.push_back('{wr: 1'b0, addr: bus.daddr, val: pattern(bus.daddr)});
                upd = 1'b0;
                #1;
            end
            if (bus.grant == GRANT_DATA && prev != GRANT_DATA) dg++;
            prev = bus.grant;
            if (bus.grant == GRANT_FETCH) begin
                seen = 1'b1;
                break;
            end
            if (!bus.dwait) upd = 1'b1;
        end
        check_eq("s_fetch_forced", 32'(seen), 32'd1);
        check_eq("s_data_grants", 32'(dg), 32'd4);
        check_eq("s_cnt_clr", 32'(dut.starve_cnt_q), 32'd0);
        wait_done(1'b0, "s_f_timeout", n);
        step();
        bus.iREN = 1'b0;
        wait_done(1'b1, "s_d_timeout", n);
        step();
        bus.dREN = 1'b0;

        // Abort: data drops its request one cycle into the grant.
        ram_lat   = 3;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        step();
        check_eq("a_ramREN_up", 32'(bus.ramREN), 32'd1);
        bus.dREN = 1'b0;
        #1;
        check_eq("a_ramREN_drop", 32'(bus.ramREN), 32'd0);
        check_eq("a_dwait_no_pulse", 32'(bus.dwait), 32'd1);
        step();
        check_eq("a_idle_grant", 32'(bus.grant), 32'(GRANT_NONE));

        // ERROR then retry on fetch.
        ram_lat    = 1;
        err_inject = 1'b1;
        bus.iREN   = 1'b1;
        bus.iaddr  = 32'h60;
        iq.push_back('{wr: 1'b0, addr: 32'h60, val: pattern(32'h60)});
        step();
        check_eq("e_grant", 32'(bus.grant), 32'(GRANT_FETCH));
        step();
        check_eq("e_iwait_on_err", 32'(bus.iwait), 32'd1);
        step();
        check_eq("e_back_idle", 32'(bus.grant), 32'(GRANT_NONE));
        err_inject = 1'b0;
        step();
        check_eq("e_regrant", 32'(bus.grant), 32'(GRANT_FETCH));
        wait_done(1'b0, "e_timeout", n);
        check_eq("e_retry_latency", 32'(n), 32'd1);
        step();
        bus.iREN = 1'b0;

        // Asynchronous reset in the middle of a data write.
        ram_lat    = 3;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h300;
        bus.dstore = 32'hCAFE;
        step();
        check_eq("r_ramWEN_up", 32'(bus.ramWEN), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("r_ramWEN_drop", 32'(bus.ramWEN), 32'd0);
        check_eq("r_grant_none", 32'(bus.grant), 32'(GRANT_NONE));
        bus.dWEN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        step();
        check_eq("r_post_grant", 32'(bus.grant), 32'(GRANT_NONE));

        step();
        check_eq("iq_drained", 32'(iq.size()), 32'd0);
        check_eq("dq_drained", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
